// File: rtl/dmem_bus_model.sv
// D-bus data memory responder: word/half/byte RAM access with configurable ack latency,
// stdout byte port and sticky exit request. Define DMEM_JITTER_EN for LFSR-randomised extra latency.
module dmem_bus_model #(
    parameter int              AW          = 32,
    parameter int              DEPTH       = 2048,
    parameter logic [AW-1:0]   BASE_ADDR   = 32'h0800_0000,
    parameter int              LATENCY     = 1,
    parameter logic [AW-1:0]   STDOUT_ADDR = 32'hf000_0000,
    parameter logic [AW-1:0]   EXIT_ADDR   = 32'hff00_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mreq,
    input  logic          write,
    input  logic [1:0]    size,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          ack_n,
    output logic          err,
    output logic          stdout_valid,
    output logic [7:0]    stdout_char,
    output logic          exit_req
);
    localparam int IW = $clog2(DEPTH);
    // Range compare is done one bit wider so the top of memory cannot wrap past zero.
    localparam logic [AW:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [AW:0] LIMIT_EXT = BASE_EXT + ((AW+1)'(DEPTH) << 2);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t          state_reg, state_next;
    logic [4:0]      cnt_reg, cnt_next, cnt_load;
    logic            write_reg;
    logic [1:0]      size_reg;
    logic [AW-1:0]   addr_reg;
    logic [31:0]     wdata_reg;
    logic            exit_reg;
    logic [7:0]      char_reg;
    logic [31:0]     mem [DEPTH];
    logic [31:0]     mem_q;

    logic            is_exit, is_stdout, in_range, misaligned, err_calc, ram_hit, stdout_hit, mem_we;
    logic [IW-1:0]   idx_req, rd_idx;
    logic [3:0]      be;
    logic [3:0][7:0] wlane;
    logic [31:0]     rd_shift, load_val;

`ifdef DMEM_JITTER_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign cnt_load = 5'(LATENCY - 1) + {3'b000, lfsr_reg[1:0]};
`else
    assign cnt_load = 5'(LATENCY - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (mreq) begin
                    cnt_next   = cnt_load;
                    state_next = (cnt_load == 5'd0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!mreq) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 5'd1;
                    if (cnt_reg == 5'd1) begin
                        state_next = ACK;
                    end
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg <= 1'b0;
            size_reg  <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (state_reg == IDLE && mreq) begin
            write_reg <= write;
            size_reg  <= size;
            addr_reg  <= addr;
            wdata_reg <= wdata;
        end
    end

    // Decode of the latched request; MMIO addresses take precedence over RAM.
    always_comb begin
        is_exit    = (addr_reg == EXIT_ADDR);
        is_stdout  = !is_exit && (addr_reg == STDOUT_ADDR);
        in_range   = ({1'b0, addr_reg} >= BASE_EXT) && ({1'b0, addr_reg} < LIMIT_EXT);
        misaligned = (size_reg == 2'b00 && addr_reg[1:0] != 2'b00) ||
                     (size_reg == 2'b01 && addr_reg[0]);
        if (is_exit) begin
            err_calc = 1'b0;
        end else if (is_stdout) begin
            err_calc = write_reg && (size_reg != 2'b10);
        end else begin
            err_calc = misaligned || (size_reg == 2'b11) || !in_range;
        end
        ram_hit    = !is_exit && !is_stdout && !err_calc;
        stdout_hit = is_stdout && write_reg && (size_reg == 2'b10);
        case (size_reg)
            2'b10:   be = 4'b0001 << addr_reg[1:0];
            2'b01:   be = addr_reg[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign idx_req = IW'(({1'b0, addr_reg} - BASE_EXT) >> 2);
    // In IDLE the read port already follows the incoming address so a single-cycle ack has data.
    assign rd_idx  = (state_reg == IDLE) ? IW'(({1'b0, addr} - BASE_EXT) >> 2) : idx_req;
    assign mem_we  = (state_reg == ACK) && write_reg && ram_hit && !rst;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wlane[gi] = (size_reg == 2'b10) ? wdata_reg[7:0] :
                           (size_reg == 2'b01) ? wdata_reg[(gi % 2) * 8 +: 8] :
                                                 wdata_reg[gi * 8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx_req][b * 8 +: 8] <= wlane[b];
                end
            end
        end
        mem_q <= mem[rd_idx];
    end

    always_comb begin
        rd_shift = mem_q >> {addr_reg[1:0], 3'b000};
        case (size_reg)
            2'b10:   load_val = {24'h0, rd_shift[7:0]};
            2'b01:   load_val = {16'h0, rd_shift[15:0]};
            default: load_val = mem_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exit_reg <= 1'b0;
            char_reg <= '0;
        end else if (state_reg == ACK && write_reg) begin
            if (is_exit) begin
                exit_reg <= 1'b1;
            end
            if (stdout_hit) begin
                char_reg <= wdata_reg[7:0];
            end
        end
    end

    always_comb begin
        ack_n        = (state_reg != ACK);
        err          = (state_reg == ACK) && err_calc;
        rdata        = (state_reg == ACK && ram_hit && !write_reg) ? load_val : 32'h0;
        stdout_valid = (state_reg == ACK) && stdout_hit;
        stdout_char  = stdout_valid ? wdata_reg[7:0] : char_reg;
        exit_req     = exit_reg;
    end
endmodule

// File: tb/tb_dmem_bus_model.sv
// Scoreboard bench for dmem_bus_model: a LATENCY=1 and a LATENCY=4 instance share clock and reset.
module tb_dmem_bus_model;
    logic        clk = 1'b0;
    logic        rst;
    logic        mreq [2];
    logic        write [2];
    logic [1:0]  size [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack_n [2];
    logic        err [2];
    logic        stdout_valid [2];
    logic [7:0]  stdout_char [2];
    logic        exit_req [2];

    always #5 clk = ~clk;

    dmem_bus_model #(.LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst), .mreq(mreq[0]), .write(write[0]), .size(size[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ack_n(ack_n[0]), .err(err[0]),
        .stdout_valid(stdout_valid[0]), .stdout_char(stdout_char[0]), .exit_req(exit_req[0])
    );

    dmem_bus_model #(.LATENCY(4)) u_dut1 (
        .clk(clk), .rst(rst), .mreq(mreq[1]), .write(write[1]), .size(size[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ack_n(ack_n[1]), .err(err[1]),
        .stdout_valid(stdout_valid[1]), .stdout_char(stdout_char[1]), .exit_req(exit_req[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          issue;
        int          tag;
    } exp_t;

    exp_t       exp_q0 [$];
    exp_t       exp_q1 [$];
    logic [7:0] char_q0 [$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         txn = 0;
    logic [31:0] ref_mem [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon_check(input int d, input exp_t e);
        int lat;
        int l_min;
        lat   = cyc - e.issue;
        l_min = (d == 0) ? 1 : 4;
        $display("dut%0d txn %0d rdata=%h err=%b latency=%0d", d, e.tag, rdata[d], err[d], lat);
        chk($sformatf("txn%0d_rdata", e.tag), rdata[d], e.rdata);
        chk($sformatf("txn%0d_err", e.tag), {31'b0, err[d]}, {31'b0, e.err});
`ifdef DMEM_JITTER_EN
        chk($sformatf("txn%0d_latency_in_range", e.tag),
            {31'b0, (lat >= l_min && lat <= l_min + 3)}, 32'd1);
`else
        chk($sformatf("txn%0d_latency", e.tag), lat, l_min);
`endif
    endtask

    // Response monitors: pop the expected entry whenever an ack is presented.
    always @(negedge clk) begin
        if (ack_n[0] === 1'b0) begin
            if (exp_q0.size() == 0) chk("dut0_unexpected_ack", 32'd1, 32'd0);
            else mon_check(0, exp_q0.pop_front());
        end
        if (ack_n[1] === 1'b0) begin
            if (exp_q1.size() == 0) chk("dut1_unexpected_ack", 32'd1, 32'd0);
            else mon_check(1, exp_q1.pop_front());
        end
        if (stdout_valid[0] === 1'b1) begin
            if (char_q0.size() == 0) chk("dut0_unexpected_stdout", 32'd1, 32'd0);
            else chk("stdout_char", {24'b0, stdout_char[0]}, {24'b0, char_q0.pop_front()});
        end
        if (stdout_valid[1] === 1'b1) chk("dut1_unexpected_stdout", 32'd1, 32'd0);
    end

    task automatic access(input int d, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        bit   seen;
        seen    = 1'b0;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.issue = cyc;
        e.tag   = txn++;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        write[d] = wr;
        size[d]  = sz;
        addr[d]  = a;
        wdata[d] = wd;
        mreq[d]  = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ack_n[d] === 1'b0) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout dut%0d txn %0d: got no ack, required ack", d, e.tag);
            if (d == 0) void'(exp_q0.pop_back());
            else        void'(exp_q1.pop_back());
        end else begin
            @(posedge clk);
            #1;
        end
        mreq[d] = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_ack_n%0d", tag, d), {31'b0, ack_n[d]}, 32'd1);
            chk($sformatf("%s_rdata%0d", tag, d), rdata[d], 32'd0);
            chk($sformatf("%s_err%0d", tag, d), {31'b0, err[d]}, 32'd0);
            chk($sformatf("%s_stdout_valid%0d", tag, d), {31'b0, stdout_valid[d]}, 32'd0);
            chk($sformatf("%s_stdout_char%0d", tag, d), {24'b0, stdout_char[d]}, 32'd0);
            chk($sformatf("%s_exit_req%0d", tag, d), {31'b0, exit_req[d]}, 32'd0);
        end
    endtask

    initial begin
        int acks;
        int wi;
        logic [31:0] val;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mreq[d] = 1'b0; write[d] = 1'b0; size[d] = 2'b00; addr[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;

        // Basic word, byte and halfword traffic on the single-cycle instance
        access(0, 1, 2'b00, 32'h0800_0000, 32'hDEAD_BEEF, 32'h0, 0);
        access(0, 0, 2'b00, 32'h0800_0000, 32'h0, 32'hDEAD_BEEF, 0);
        access(0, 1, 2'b00, 32'h0800_0004, 32'h1122_3344, 32'h0, 0);
        access(0, 1, 2'b10, 32'h0800_0006, 32'h0000_005A, 32'h0, 0);
        access(0, 0, 2'b01, 32'h0800_0006, 32'h0, 32'h0000_115A, 0);
        access(0, 0, 2'b00, 32'h0800_0004, 32'h0, 32'h115A_3344, 0);
        access(0, 0, 2'b10, 32'h0800_0007, 32'h0, 32'h0000_0011, 0);
        access(0, 0, 2'b10, 32'h0800_0005, 32'h0, 32'h0000_0033, 0);
        access(0, 1, 2'b01, 32'h0800_0002, 32'hFFFF_BEEF, 32'h0, 0);
        access(0, 0, 2'b00, 32'h0800_0000, 32'h0, 32'hBEEF_BEEF, 0);

        // Error cases leave memory untouched
        access(0, 0, 2'b01, 32'h0800_0001, 32'h0, 32'h0, 1);
        access(0, 0, 2'b00, 32'h0000_0100, 32'h0, 32'h0, 1);
        access(0, 1, 2'b00, 32'h0000_0100, 32'h5555_5555, 32'h0, 1);
        access(0, 1, 2'b01, 32'h0800_0001, 32'h0000_1234, 32'h0, 1);
        access(0, 0, 2'b00, 32'h0800_0002, 32'h0, 32'h0, 1);
        access(0, 0, 2'b11, 32'h0800_0000, 32'h0, 32'h0, 1);
        access(0, 0, 2'b00, 32'h0800_0000, 32'h0, 32'hBEEF_BEEF, 0);

        // Memory boundaries
        access(0, 1, 2'b00, 32'h0800_1FFC, 32'hA5A5_0001, 32'h0, 0);
        access(0, 0, 2'b00, 32'h0800_1FFC, 32'h0, 32'hA5A5_0001, 0);
        access(0, 0, 2'b00, 32'h0800_2000, 32'h0, 32'h0, 1);
        access(0, 0, 2'b00, 32'h07FF_FFFC, 32'h0, 32'h0, 1);

        // Stdout port
        char_q0.push_back(8'h48);
        access(0, 1, 2'b10, 32'hF000_0000, 32'h0000_0048, 32'h0, 0);
        char_q0.push_back(8'h69);
        access(0, 1, 2'b10, 32'hF000_0000, 32'h0000_0069, 32'h0, 0);
        access(0, 1, 2'b01, 32'hF000_0000, 32'h0000_0041, 32'h0, 1);
        access(0, 0, 2'b10, 32'hF000_0000, 32'h0, 32'h0, 0);
        chk("stdout_char_hold", {24'b0, stdout_char[0]}, 32'h69);
        chk("stdout_all_pulses_seen", char_q0.size(), 0);

        // Exit request is sticky
        chk("exit_before", {31'b0, exit_req[0]}, 32'd0);
        access(0, 1, 2'b00, 32'hFF00_0000, 32'h0000_0001, 32'h0, 0);
        chk("exit_set", {31'b0, exit_req[0]}, 32'd1);
        access(0, 0, 2'b00, 32'hFF00_0000, 32'h0, 32'h0, 0);
        access(0, 0, 2'b00, 32'h0800_0004, 32'h0, 32'h115A_3344, 0);
        chk("exit_held", {31'b0, exit_req[0]}, 32'd1);

        // Random word traffic against a reference array
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            access(0, 1, 2'b00, 32'h0800_0100 + 32'(i * 4), ref_mem[i], 32'h0, 0);
        end
        for (int i = 0; i < 60; i++) begin
            wi = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                val = $urandom;
                ref_mem[wi] = val;
                access(0, 1, 2'b00, 32'h0800_0100 + 32'(wi * 4), val, 32'h0, 0);
            end else begin
                access(0, 0, 2'b00, 32'h0800_0100 + 32'(wi * 4), 32'h0, ref_mem[wi], 0);
            end
        end

        // Latency-4 instance
        access(1, 1, 2'b00, 32'h0800_0010, 32'h1234_5678, 32'h0, 0);
        access(1, 0, 2'b00, 32'h0800_0010, 32'h0, 32'h1234_5678, 0);

        // Abort: mreq dropped in the second cycle after acceptance
        write[1] = 1'b1; size[1] = 2'b00; addr[1] = 32'h0800_0010; wdata[1] = 32'hCAFE_BABE;
        mreq[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 mreq[1] = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack_n[1] === 1'b0) acks++;
        end
        chk("abort_no_ack", acks, 0);
        @(posedge clk);
        #1;
        access(1, 0, 2'b00, 32'h0800_0010, 32'h0, 32'h1234_5678, 0);

        // Reset in WAIT with a pending store
        write[1] = 1'b1; size[1] = 2'b00; addr[1] = 32'h0800_0010; wdata[1] = 32'h0BAD_F00D;
        mreq[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        mreq[1] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        @(posedge clk);
        #1;
        access(1, 0, 2'b00, 32'h0800_0010, 32'h0, 32'h1234_5678, 0);
        access(0, 0, 2'b00, 32'h0800_0004, 32'h0, 32'h115A_3344, 0);

        repeat (4) @(negedge clk);
        chk("dut0_queue_drained", exp_q0.size(), 0);
        chk("dut1_queue_drained", exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
